// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared encodings for the uncached data-cache responder
package dcache_pkg;

  typedef enum logic [2:0] {
    MAIN_IDLE    = 3'd0,
    MAIN_RD_REQ  = 3'd1,
    MAIN_RD_WAIT = 3'd2,
    MAIN_RD_RESP = 3'd3,
    MAIN_WR_RESP = 3'd4
  } main_state_e;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_REQ  = 1'b1
  } wb_state_e;

  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic       OP_LOAD   = 1'b0;
  localparam logic       OP_STORE  = 1'b1;

endpackage

// File: rtl/dcache_uc_wbuf.sv
// rtl/dcache_uc_wbuf.sv - one-entry store buffer driving the bridge write channel
module dcache_uc_wbuf
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [3:0]        load_wstrb,
  input  logic [31:0]       load_wdata,
  output logic              wb_idle,
  output logic              wr_req,
  output logic [2:0]        wr_type,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_wstrb,
  output logic [31:0]       wr_data,
  input  logic              wr_rdy
);

  wb_state_e         wb_q, wb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;

  // Entry is only loaded while idle, so the payload stays frozen during WB_REQ.
  // A zero-strobe store is recorded but never sent to the bridge.
  always_comb begin
    wb_d    = wb_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    unique case (wb_q)
      WB_IDLE: begin
        if (load_en) begin
          addr_d  = load_addr;
          wstrb_d = load_wstrb;
          wdata_d = load_wdata;
          if (load_wstrb != 4'b0000) begin
            wb_d = WB_REQ;
          end
        end
      end
      WB_REQ: begin
        if (wr_rdy) begin
          wb_d = WB_IDLE;
        end
      end
      default: wb_d = WB_IDLE;
    endcase
  end

  // Buffer state and payload registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_q    <= WB_IDLE;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      wb_q    <= wb_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

  assign wb_idle  = (wb_q == WB_IDLE);
  assign wr_req   = (wb_q == WB_REQ);
  assign wr_type  = TYPE_WORD;
  assign wr_addr  = addr_q;
  assign wr_wstrb = wstrb_q;
  assign wr_data  = wdata_q;

endmodule

// File: rtl/dcache_uncache_resp.sv
// rtl/dcache_uncache_resp.sv - uncached load/store responder for the data-cache port
module dcache_uncache_resp
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  logic              op,
  input  logic [7:0]        index,
  input  logic [19:0]       tag,
  input  logic [3:0]        offset,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              rd_req,
  output logic [2:0]        rd_type,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_rdy,
  input  logic              ret_valid,
  input  logic              ret_last,
  input  logic [31:0]       ret_data,
  output logic              wr_req,
  output logic [2:0]        wr_type,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_wstrb,
  output logic [31:0]       wr_data,
  input  logic              wr_rdy
);

  main_state_e       main_q, main_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              data_ok_q, data_ok_d;
  logic              rd_req_q, rd_req_d;

  logic              wb_idle;
  logic              accept;
  logic              store_accept;
  logic [ADDR_W-1:0] req_addr;

  // A pending buffered store blocks all new requests, so loads never pass stores.
  assign addr_ok      = (main_q == MAIN_IDLE) && wb_idle;
  assign accept       = valid && addr_ok;
  assign store_accept = accept && (op == OP_STORE);
  assign req_addr     = {tag, index, offset};

  // Main FSM next state; data_ok and rd_req are registered alongside the state.
  always_comb begin
    main_d    = main_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    data_ok_d = 1'b0;
    rd_req_d  = rd_req_q;
    unique case (main_q)
      MAIN_IDLE: begin
        if (accept) begin
          addr_d = req_addr;
          if (op == OP_LOAD) begin
            main_d   = MAIN_RD_REQ;
            rd_req_d = 1'b1;
          end else begin
            main_d    = MAIN_WR_RESP;
            data_ok_d = 1'b1;
          end
        end
      end
      MAIN_RD_REQ: begin
        if (rd_rdy) begin
          main_d   = MAIN_RD_WAIT;
          rd_req_d = 1'b0;
        end
      end
      MAIN_RD_WAIT: begin
        if (ret_valid) begin
          rdata_d = ret_data;
          if (ret_last) begin
            main_d    = MAIN_RD_RESP;
            data_ok_d = 1'b1;
          end
        end
      end
      MAIN_RD_RESP: main_d = MAIN_IDLE;
      MAIN_WR_RESP: main_d = MAIN_IDLE;
      default: begin
        main_d   = MAIN_IDLE;
        rd_req_d = 1'b0;
      end
    endcase
  end

  // Main FSM state, address latch and load-data register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q    <= MAIN_IDLE;
      addr_q    <= '0;
      rdata_q   <= '0;
      data_ok_q <= 1'b0;
      rd_req_q  <= 1'b0;
    end else begin
      main_q    <= main_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      data_ok_q <= data_ok_d;
      rd_req_q  <= rd_req_d;
    end
  end

  assign data_ok = data_ok_q;
  assign rdata   = rdata_q;
  assign rd_req  = rd_req_q;
  assign rd_type = TYPE_WORD;
  assign rd_addr = addr_q;

  dcache_uc_wbuf #(
    .ADDR_W (ADDR_W)
  ) u_wbuf (
    .clk        (clk),
    .resetn     (resetn),
    .load_en    (store_accept),
    .load_addr  (req_addr),
    .load_wstrb (wstrb),
    .load_wdata (wdata),
    .wb_idle    (wb_idle),
    .wr_req     (wr_req),
    .wr_type    (wr_type),
    .wr_addr    (wr_addr),
    .wr_wstrb   (wr_wstrb),
    .wr_data    (wr_data),
    .wr_rdy     (wr_rdy)
  );

endmodule

// File: tb/tb_dcache_uncache_resp.sv
// tb/tb_dcache_uncache_resp.sv - directed self-checking bench for dcache_uncache_resp
module tb_dcache_uncache_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid;
  logic        op;
  logic [7:0]  index;
  logic [19:0] tag;
  logic [3:0]  offset;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
  logic        wr_req;
  logic [2:0]  wr_type;
  logic [31:0] wr_addr;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_data;
  logic        wr_rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_uncache_resp #(.ADDR_W(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .op        (op),
    .index     (index),
    .tag       (tag),
    .offset    (offset),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .addr_ok   (addr_ok),
    .data_ok   (data_ok),
    .rdata     (rdata),
    .rd_req    (rd_req),
    .rd_type   (rd_type),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_last  (ret_last),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_type   (wr_type),
    .wr_addr   (wr_addr),
    .wr_wstrb  (wr_wstrb),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic o, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    valid  = 1'b1;
    op     = o;
    tag    = a[31:12];
    index  = a[11:4];
    offset = a[3:0];
    wstrb  = s;
    wdata  = d;
  endtask

  initial begin
    resetn = 1'b0; valid = 1'b0; op = 1'b0; index = '0; tag = '0; offset = '0;
    wstrb = '0; wdata = '0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
    ret_data = '0; wr_rdy = 1'b0;
    #12;
    chk("rst_data_ok", 32'(data_ok), 32'd0);
    chk("rst_rd_req", 32'(rd_req), 32'd0);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rd_addr", rd_addr, 32'h0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_wstrb", 32'(wr_wstrb), 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rd_type", 32'(rd_type), 32'h2);
    chk("wr_type", 32'(wr_type), 32'h2);
    @(negedge clk);
    resetn = 1'b1;
    step();
    chk("rel_addr_ok", 32'(addr_ok), 32'd1);

    // Load: rd_rdy immediately, single-beat return.
    set_req(1'b0, 32'hBFAF_8000, 4'h0, 32'h0);
    step(); valid = 1'b0;                         // cycle 1
    chk("ld_rd_req_c1", 32'(rd_req), 32'd1);
    chk("ld_rd_addr_c1", rd_addr, 32'hBFAF_8000);
    chk("ld_addr_ok_c1", 32'(addr_ok), 32'd0);
    rd_rdy = 1'b1;
    step(); rd_rdy = 1'b0;                        // cycle 2
    chk("ld_rd_req_c2", 32'(rd_req), 32'd0);
    chk("ld_data_ok_c2", 32'(data_ok), 32'd0);
    ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h1234_5678;
    step(); ret_valid = 1'b0; ret_last = 1'b0;    // cycle 3
    chk("ld_data_ok_c3", 32'(data_ok), 32'd1);
    chk("ld_rdata_c3", rdata, 32'h1234_5678);
    chk("ld_addr_ok_c3", 32'(addr_ok), 32'd0);
    step();                                       // cycle 4
    chk("ld_data_ok_c4", 32'(data_ok), 32'd0);
    chk("ld_addr_ok_c4", 32'(addr_ok), 32'd1);

    // Store with wr_rdy held low for cycles 1..5; a load offered meanwhile is ignored.
    set_req(1'b1, 32'h1FD0_F010, 4'b0011, 32'hDEAD_BEEF);
    step(); valid = 1'b0;                         // cycle 1
    chk("st_data_ok_c1", 32'(data_ok), 32'd1);
    chk("st_wr_req_c1", 32'(wr_req), 32'd1);
    chk("st_wr_addr_c1", wr_addr, 32'h1FD0_F010);
    chk("st_wr_wstrb_c1", 32'(wr_wstrb), 32'h3);
    chk("st_wr_data_c1", wr_data, 32'hDEAD_BEEF);
    chk("st_addr_ok_c1", 32'(addr_ok), 32'd0);
    for (int c = 2; c <= 6; c++) begin
      if (c == 3) set_req(1'b0, 32'h0000_1230, 4'h0, 32'h0);
      if (c == 6) valid = 1'b0;
      step();
      chk($sformatf("st_wr_req_c%0d", c), 32'(wr_req), 32'd1);
      chk($sformatf("st_wr_addr_c%0d", c), wr_addr, 32'h1FD0_F010);
      chk($sformatf("st_wr_wstrb_c%0d", c), 32'(wr_wstrb), 32'h3);
      chk($sformatf("st_data_ok_c%0d", c), 32'(data_ok), 32'd0);
      chk($sformatf("st_addr_ok_c%0d", c), 32'(addr_ok), 32'd0);
      chk($sformatf("st_rd_req_c%0d", c), 32'(rd_req), 32'd0);
    end
    wr_rdy = 1'b1;                                // handshake in cycle 6
    step(); wr_rdy = 1'b0;                        // cycle 7
    chk("st_wr_req_c7", 32'(wr_req), 32'd0);
    chk("st_addr_ok_c7", 32'(addr_ok), 32'd1);
    chk("st_data_ok_c7", 32'(data_ok), 32'd0);
    step();                                       // cycle 8
    chk("ign_rd_req_c8", 32'(rd_req), 32'd0);
    chk("ign_data_ok_c8", 32'(data_ok), 32'd0);

    // Zero-strobe store: completes without a bus write.
    set_req(1'b1, 32'h0000_0040, 4'b0000, 32'hCAFE_F00D);
    step(); valid = 1'b0;                         // cycle 1
    chk("zs_data_ok_c1", 32'(data_ok), 32'd1);
    chk("zs_wr_req_c1", 32'(wr_req), 32'd0);
    chk("zs_addr_ok_c1", 32'(addr_ok), 32'd0);
    step();                                       // cycle 2
    chk("zs_wr_req_c2", 32'(wr_req), 32'd0);
    chk("zs_addr_ok_c2", 32'(addr_ok), 32'd1);
    chk("zs_data_ok_c2", 32'(data_ok), 32'd0);

    // Multi-beat return, rd_rdy delayed one cycle, stray ret_valid in RD_REQ.
    set_req(1'b0, 32'h8000_0104, 4'h0, 32'h0);
    step(); valid = 1'b0;                         // cycle 1 (RD_REQ)
    ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h0000_00AA;
    step(); ret_valid = 1'b0; ret_last = 1'b0;    // cycle 2
    chk("mb_rd_req_hold", 32'(rd_req), 32'd1);
    chk("mb_rd_addr_hold", rd_addr, 32'h8000_0104);
    chk("mb_stray_data_ok", 32'(data_ok), 32'd0);
    rd_rdy = 1'b1;
    step(); rd_rdy = 1'b0;                        // cycle 3 (RD_WAIT)
    for (int b = 1; b <= 3; b++) begin
      ret_valid = 1'b1; ret_last = (b == 3); ret_data = 32'(b);
      chk($sformatf("mb_data_ok_b%0d", b), 32'(data_ok), 32'd0);
      step();
    end
    ret_valid = 1'b0; ret_last = 1'b0;            // cycle 6
    chk("mb_data_ok", 32'(data_ok), 32'd1);
    chk("mb_rdata", rdata, 32'h3);
    step();
    chk("mb_data_ok_once", 32'(data_ok), 32'd0);
    chk("mb_addr_ok", 32'(addr_ok), 32'd1);

    // Reset while in RD_WAIT after one non-final beat.
    set_req(1'b0, 32'h0000_2000, 4'h0, 32'h0);
    step(); valid = 1'b0; rd_rdy = 1'b1;          // cycle 1
    step(); rd_rdy = 1'b0;                        // cycle 2 (RD_WAIT)
    ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'h5555_AAAA;
    step(); ret_valid = 1'b0;                     // cycle 3
    chk("rr_rdata_pre", rdata, 32'h5555_AAAA);
    chk("rr_addr_ok_pre", 32'(addr_ok), 32'd0);
    resetn = 1'b0;
    #1;
    chk("rr_rd_req", 32'(rd_req), 32'd0);
    chk("rr_data_ok", 32'(data_ok), 32'd0);
    chk("rr_rdata", rdata, 32'h0);
    chk("rr_rd_addr", rd_addr, 32'h0);
    chk("rr_addr_ok", 32'(addr_ok), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    step();
    set_req(1'b0, 32'h0000_3008, 4'h0, 32'h0);
    step(); valid = 1'b0;
    chk("rr2_rd_req", 32'(rd_req), 32'd1);
    chk("rr2_rd_addr", rd_addr, 32'h0000_3008);
    rd_rdy = 1'b1;
    step(); rd_rdy = 1'b0;
    ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h0BAD_F00D;
    step(); ret_valid = 1'b0; ret_last = 1'b0;
    chk("rr2_data_ok", 32'(data_ok), 32'd1);
    chk("rr2_rdata", rdata, 32'h0BAD_F00D);
    step();
    chk("rr2_addr_ok", 32'(addr_ok), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
